// File: rtl/softermax_pkg.sv
// softermax_pkg: shared state encoding, datapath widths and ceiling helper for softermax_accum
package softermax_pkg;
    localparam int BW_DEF = 8;
    localparam int ACCUM_BW_DEF = 16;
    localparam int D_W = BW_DEF + 2;
    localparam int SH_W = $clog2(ACCUM_BW_DEF) + 1;
    typedef enum logic [1:0] {ACCUM, EXP, OUT} state_t;
    function automatic logic signed [D_W-1:0] ceil_int(input logic signed [D_W-1:0] x, input int ifw);
        logic signed [D_W-1:0] t;
        t = x + $signed(D_W'((1 << ifw) - 1));
        return t >>> ifw;
    endfunction
endpackage

// File: rtl/softermax_accum_pow2_unit.sv
// pow2_unit: combinational 2^d for d <= 0, result in ACCUM_FW fractional bits
module pow2_unit #(
    parameter int BW = 8,
    parameter int IN_FW = 4,
    parameter int ACCUM_BW = 16,
    parameter int ACCUM_FW = 6
) (
    input  logic signed [BW+1:0]   d,
    output logic [ACCUM_BW-1:0]    p
);
    logic signed [BW+1:0] fl;
    logic [BW+1:0] k;
    logic [ACCUM_BW-1:0] base;
    always_comb begin
        fl = d >>> IN_FW;
        k = -fl;
        base = ACCUM_BW'(1 << ACCUM_FW) + (ACCUM_BW'(d[IN_FW-1:0]) << (ACCUM_FW - IN_FW));
        p = (k >= (BW+2)'(ACCUM_FW + 2)) ? '0 : base >> k;
    end
endmodule

// File: rtl/softermax_accum.sv
// softermax_accum: online max/denominator accumulation then a second pass producing 2^(x-max) per score
module softermax_accum
    import softermax_pkg::*;
#(
    parameter int BW = 8,
    parameter int IN_FW = 4,
    parameter int ACCUM_BW = 16,
    parameter int ACCUM_FW = 6,
    parameter int VEC_SIZE = 10
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic signed [BW-1:0]               in_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [VEC_SIZE-1:0][ACCUM_BW-1:0]  vec_out,
    output logic [ACCUM_BW-1:0]                denom_out,
    output logic signed [BW-1:0]               max_out
);
    localparam int CW = (VEC_SIZE > 1) ? $clog2(VEC_SIZE) : 1;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, idx_q, idx_d;
    logic first_q, first_d;
    logic signed [BW-1:0] m_q, m_d, max_q, max_d;
    logic [ACCUM_BW-1:0] den_q, den_d, denom_q, denom_d;
    logic signed [BW-1:0] sbuf_q [VEC_SIZE];
    logic signed [BW-1:0] sbuf_d [VEC_SIZE];
    logic [VEC_SIZE-1:0][ACCUM_BW-1:0] vec_q, vec_d;
    logic signed [D_W-1:0] x, c, mx, diff, d_acc, d_exp;
    logic [ACCUM_BW-1:0] p_acc, p_exp, kept;
    logic [ACCUM_BW:0] sum;
    logic rise;

    pow2_unit #(.BW(BW), .IN_FW(IN_FW), .ACCUM_BW(ACCUM_BW), .ACCUM_FW(ACCUM_FW))
        u_pow2_acc (.d(d_acc), .p(p_acc));
    pow2_unit #(.BW(BW), .IN_FW(IN_FW), .ACCUM_BW(ACCUM_BW), .ACCUM_FW(ACCUM_FW))
        u_pow2_exp (.d(d_exp), .p(p_exp));

    always_comb begin
        x = D_W'(in_data);
        c = ceil_int(x, IN_FW);
        mx = D_W'(m_q);
        rise = first_q || (c > mx);
        diff = c - mx;
        d_acc = x - ((rise ? c : mx) <<< IN_FW);
        d_exp = D_W'(sbuf_q[idx_q]) - (mx <<< IN_FW);
        // a rising max rescales the old sum; shifts past the word width flush it
        kept = first_q ? '0 : !rise ? den_q : (diff >= D_W'(ACCUM_BW)) ? '0 : den_q >> SH_W'(diff);
        sum = {1'b0, kept} + {1'b0, p_acc};
        state_d = state_q;
        cnt_d = cnt_q;
        idx_d = idx_q;
        first_d = first_q;
        m_d = m_q;
        den_d = den_q;
        max_d = max_q;
        denom_d = denom_q;
        sbuf_d = sbuf_q;
        vec_d = vec_q;
        if (state_q == ACCUM && in_valid) begin
            sbuf_d[cnt_q] = in_data;
            first_d = 1'b0;
            m_d = rise ? BW'(c) : m_q;
            den_d = sum[ACCUM_BW] ? '1 : sum[ACCUM_BW-1:0];
            cnt_d = (cnt_q == CW'(VEC_SIZE - 1)) ? '0 : cnt_q + CW'(1);
            state_d = (cnt_q == CW'(VEC_SIZE - 1)) ? EXP : ACCUM;
        end else if (state_q == EXP) begin
            vec_d[idx_q] = p_exp;
            idx_d = (idx_q == CW'(VEC_SIZE - 1)) ? '0 : idx_q + CW'(1);
            if (idx_q == CW'(VEC_SIZE - 1)) begin
                state_d = OUT;
                denom_d = den_q;
                max_d = m_q;
            end
        end else if (state_q == OUT && out_ready) begin
            state_d = ACCUM;
            first_d = 1'b1;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ACCUM;
            cnt_q <= '0;
            idx_q <= '0;
            first_q <= 1'b1;
            m_q <= '0;
            den_q <= '0;
            max_q <= '0;
            denom_q <= '0;
            sbuf_q <= '{default: '0};
            vec_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            first_q <= first_d;
            m_q <= m_d;
            den_q <= den_d;
            max_q <= max_d;
            denom_q <= denom_d;
            sbuf_q <= sbuf_d;
            vec_q <= vec_d;
        end
    end

    assign in_ready = (state_q == ACCUM);
    assign out_valid = (state_q == OUT);
    assign vec_out = vec_q;
    assign denom_out = denom_q;
    assign max_out = max_q;
endmodule

// File: tb/tb_softermax_accum.sv
// tb_softermax_accum: directed checks of softermax_accum with VEC_SIZE=4
module tb_softermax_accum;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0;
    logic in_ready;
    logic signed [7:0] in_data = '0;
    logic out_valid;
    logic out_ready = 1'b0;
    logic [3:0][15:0] vec_out;
    logic [15:0] denom_out;
    logic signed [7:0] max_out;
    int checks = 0;
    int errors = 0;

    softermax_accum #(.BW(8), .IN_FW(4), .ACCUM_BW(16), .ACCUM_FW(6), .VEC_SIZE(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .vec_out(vec_out),
        .denom_out(denom_out), .max_out(max_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] v);
        in_valid = 1'b1;
        in_data = v;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int n = 0;
        chk({tag, "_busy"}, {63'd0, in_ready}, 64'd0);
        while (out_valid !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'd4);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_rdy"}, {63'd0, in_ready}, 64'd1);
        chk({tag, "_ovl"}, {63'd0, out_valid}, 64'd0);
    endtask

    task automatic check_res(input string tag, input logic [7:0] m, input logic [15:0] d, input logic [63:0] v);
        chk({tag, "_max"}, {56'd0, max_out}, {56'd0, m});
        chk({tag, "_den"}, {48'd0, denom_out}, {48'd0, d});
        chk({tag, "_vec"}, vec_out, v);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_ovl", {63'd0, out_valid}, 64'd0);
        chk("rst_rdy", {63'd0, in_ready}, 64'd1);
        check_res("rst", 8'd0, 16'd0, 64'd0);

        send(8'd0); send(8'd0); send(8'd0); send(8'd0);
        wait_out("s1");
        check_res("s1", 8'd0, 16'd256, {16'd64, 16'd64, 16'd64, 16'd64});
        handshake("s1");

        send(8'd0);  chk("s2_d0", {48'd0, dut.den_q}, 64'd64);
        send(8'd16); chk("s2_d1", {48'd0, dut.den_q}, 64'd96);
        send(8'd32); chk("s2_d2", {48'd0, dut.den_q}, 64'd112);
        send(8'd48); chk("s2_d3", {48'd0, dut.den_q}, 64'd120);
        wait_out("s2");
        check_res("s2", 8'd3, 16'd120, {16'd64, 16'd32, 16'd16, 16'd8});
        handshake("s2");

        send(8'd8); send(8'd8); send(8'd8); send(8'd8);
        wait_out("s3");
        check_res("s3", 8'd1, 16'd192, {16'd48, 16'd48, 16'd48, 16'd48});
        handshake("s3");

        send(8'h80); send(8'd0); send(8'd0); send(8'd0);
        wait_out("s4");
        check_res("s4", 8'd0, 16'd192, {16'd64, 16'd64, 16'd64, 16'd0});
        handshake("s4");

        send(8'd0); send(8'd0); send(8'd0); send(8'd0);
        wait_out("s5a");
        in_valid = 1'b1;
        in_data = 8'd48;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("s5_hold_ovl", {63'd0, out_valid}, 64'd1);
            chk("s5_hold_rdy", {63'd0, in_ready}, 64'd0);
            check_res("s5_hold", 8'd0, 16'd256, {16'd64, 16'd64, 16'd64, 16'd64});
        end
        in_valid = 1'b0;
        handshake("s5a");
        send(8'd0); send(8'd16); send(8'd32); send(8'd48);
        wait_out("s5b");
        check_res("s5b", 8'd3, 16'd120, {16'd64, 16'd32, 16'd16, 16'd8});
        handshake("s5b");

        send(8'd0); send(8'd16);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("s6_ovl", {63'd0, out_valid}, 64'd0);
        chk("s6_rdy", {63'd0, in_ready}, 64'd1);
        check_res("s6_rst", 8'd0, 16'd0, 64'd0);
        send(8'd0); send(8'd0); send(8'd0); send(8'd0);
        wait_out("s6");
        check_res("s6", 8'd0, 16'd256, {16'd64, 16'd64, 16'd64, 16'd64});
        handshake("s6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
